// File: rtl/interrupt_controller_if.sv
// Pipeline-side bus of the interrupt controller: config register port plus
// the request/acknowledge and mret/EPC handshake with the core.
// master = pipeline / CSR side, slave = interrupt controller.
interface interrupt_controller_if #(
    parameter int XLEN = 32
);
    logic            cfg_we;
    logic [1:0]      cfg_addr;
    logic [XLEN-1:0] cfg_wdata;
    logic [XLEN-1:0] cfg_rdata;
    logic [XLEN-1:0] pc_in;
    logic            irq_req;
    logic [XLEN-1:0] irq_vec;
    logic            irq_ack;
    logic            mret;
    logic            epc_taken;
    logic [XLEN-1:0] epc_out;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, pc_in, irq_ack, mret,
        input  cfg_rdata, irq_req, irq_vec, epc_taken, epc_out
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, pc_in, irq_ack, mret,
        output cfg_rdata, irq_req, irq_vec, epc_taken, epc_out
    );
endinterface

// File: rtl/interrupt_controller.sv
// N-channel vectored interrupt controller for the 3-stage RISC-V core.
// Per-channel enable, pending and edge/level mode, fixed priority (bit 0
// highest), request/ack handshake with the pipeline, EPC capture and return
// on mret.  Config map: 0=ENABLE 1=PENDING 2=MODE 3=STATUS.
// Build option: define IRQ_SYNC_EN to put a 2-flop synchroniser on every
// irq_in bit; without it irq_in must already be synchronous to clk.
module interrupt_controller #(
    parameter int              NUM_IRQ    = 8,
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] VEC_BASE   = XLEN'(32'h0000_0100),
    parameter int unsigned     VEC_STRIDE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_IRQ-1:0]   irq_in,
    interrupt_controller_if.slave bus
);
    localparam int ID_W = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [NUM_IRQ-1:0]  sync;
    logic [NUM_IRQ-1:0]  sync_d_reg;
    logic [NUM_IRQ-1:0]  rise;
    logic [NUM_IRQ-1:0]  enable_reg;
    logic [NUM_IRQ-1:0]  mode_reg;
    logic [NUM_IRQ-1:0]  pending_reg, pending_next;
    logic [NUM_IRQ-1:0]  req_vec;
    logic [NUM_IRQ-1:0]  id_onehot;
    logic                gie_reg;
    logic [ID_W-1:0]     id_reg;
    logic [ID_W-1:0]     sel_id;
    logic [XLEN-1:0]     irq_vec_reg;
    logic [XLEN-1:0]     vec_calc;
    logic                irq_req_reg, irq_req_next;
    logic                epc_taken_reg;
    logic [XLEN-1:0]     epc_out_reg;
    logic [XLEN-1:0]     rdata;
    logic                any_req;
    logic                cur_active;
    logic                start;
    logic                ack_take;
    logic                mret_take;
    logic                in_service;
    logic                wr_enable, wr_pending, wr_mode, wr_status;
    logic                unused_wdata;

    // Input synchronisation: optional double flop, otherwise pass-through.
`ifdef IRQ_SYNC_EN
    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            // Two-stage synchroniser for one interrupt line.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= irq_in[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign sync[gi] = sync_reg;
        end
    endgenerate
`else
    assign sync = irq_in;
`endif

    // Delayed copy of the synced lines for rising-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_d_reg <= '0;
        end else begin
            sync_d_reg <= sync;
        end
    end

    assign rise = sync & ~sync_d_reg;

    // Config write decode.
    assign wr_enable  = bus.cfg_we && (bus.cfg_addr == 2'd0);
    assign wr_pending = bus.cfg_we && (bus.cfg_addr == 2'd1);
    assign wr_mode    = bus.cfg_we && (bus.cfg_addr == 2'd2);
    assign wr_status  = bus.cfg_we && (bus.cfg_addr == 2'd3);

    assign unused_wdata = ^bus.cfg_wdata;

    // Per-channel pending update.  Edge channels: a rise sets, W1C or an
    // accepted ack of this channel clears, and a rise beats any clear in the
    // same cycle.  Level channels simply follow the synced line.
    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_pend
            logic clr;
            assign id_onehot[gi] = (id_reg == ID_W'(gi));
            assign clr = (wr_pending && bus.cfg_wdata[gi])
                       || (ack_take && id_onehot[gi]);
            assign pending_next[gi] = mode_reg[gi]
                                    ? (rise[gi] | (pending_reg[gi] & ~clr))
                                    : sync[gi];
        end
    endgenerate

    assign req_vec    = pending_reg & enable_reg;
    assign any_req    = gie_reg && (|req_vec);
    assign cur_active = |(id_onehot & req_vec);
    assign in_service = (state_reg == SERVICE);

    // Fixed-priority pick: lowest set index wins.
    always_comb begin
        sel_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                sel_id = ID_W'(i);
            end
        end
    end

    // Trap vector of the selected channel, wrapping at XLEN.
    assign vec_calc = VEC_BASE + XLEN'(sel_id) * XLEN'(VEC_STRIDE);

    // Next-state logic.  An ack is only honoured once irq_req has actually
    // been presented, and it beats a simultaneous cancel.  IDLE holds off
    // while the epc_taken pulse is out so new requests start a cycle later.
    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        ack_take   = 1'b0;
        mret_take  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (any_req && !epc_taken_reg) begin
                    start      = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (bus.irq_ack && irq_req_reg) begin
                    ack_take   = 1'b1;
                    state_next = SERVICE;
                end else if (!gie_reg || !cur_active) begin
                    state_next = IDLE;
                end
            end
            SERVICE: begin
                if (bus.mret) begin
                    mret_take  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // irq_req is high only while the FSM stays in REQ, so a request that is
    // cancelled on its first REQ cycle never reaches the pipeline.
    assign irq_req_next = (state_reg == REQ) && (state_next == REQ);

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Config registers; FSM updates of GIE take precedence over writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable_reg  <= '0;
            mode_reg    <= '0;
            pending_reg <= '0;
            gie_reg     <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            if (wr_enable) begin
                enable_reg <= bus.cfg_wdata[NUM_IRQ-1:0];
            end
            if (wr_mode) begin
                mode_reg <= bus.cfg_wdata[NUM_IRQ-1:0];
            end
            if (ack_take) begin
                gie_reg <= 1'b0;
            end else if (mret_take) begin
                gie_reg <= 1'b1;
            end else if (wr_status) begin
                gie_reg <= bus.cfg_wdata[0];
            end
        end
    end

    // Handshake outputs, latched id/vector and saved EPC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_reg        <= '0;
            irq_vec_reg   <= '0;
            irq_req_reg   <= 1'b0;
            epc_taken_reg <= 1'b0;
            epc_out_reg   <= '0;
        end else begin
            irq_req_reg   <= irq_req_next;
            epc_taken_reg <= mret_take;
            if (start) begin
                id_reg      <= sel_id;
                irq_vec_reg <= vec_calc;
            end
            if (ack_take) begin
                epc_out_reg <= bus.pc_in;
            end
        end
    end

    // Combinational register read.
    always_comb begin
        rdata = '0;
        case (bus.cfg_addr)
            2'd0:    rdata = XLEN'(enable_reg);
            2'd1:    rdata = XLEN'(pending_reg);
            2'd2:    rdata = XLEN'(mode_reg);
            default: rdata = XLEN'({id_reg, 6'b0, in_service, gie_reg});
        endcase
    end

    assign bus.cfg_rdata = rdata;
    assign bus.irq_req   = irq_req_reg;
    assign bus.irq_vec   = irq_vec_reg;
    assign bus.epc_taken = epc_taken_reg;
    assign bus.epc_out   = epc_out_reg;
endmodule
